// File: rtl/data_bus_bridge_pkg.sv
// Shared CPU data-bus encodings (request kind and access size) plus the alignment rule.
package data_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_R    = 2'd1,
        ACC_W    = 2'd2,
        ACC_X    = 2'd3
    } mem_access_t;

    typedef enum logic [1:0] {
        LEN_B = 2'd0,
        LEN_H = 2'd1,
        LEN_W = 2'd2
    } mem_len_t;

    // Any size encoding other than byte/halfword is treated as a full word.
    function automatic logic is_misaligned(input mem_len_t len, input logic [1:0] addr_lo);
        case (len)
            LEN_B:   return 1'b0;
            LEN_H:   return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Little-endian lane steering: byte enables, write-data replication, read shift and zero extension.
module bus_lane_align
    import data_bus_bridge_pkg::*;
(
    input  mem_len_t    len_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] rdata_shifted;

    assign rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_shifted;
        case (len_i)
            LEN_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'h0, rdata_shifted[7:0]};
            end
            LEN_H: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {16'h0, rdata_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_bus_bridge.sv
// CPU data bus to word-addressed memory bridge (IDLE/REQ/RESP/ERR).
// Optional acknowledge timeout enabled by defining DATA_BUS_TIMEOUT_EN.
module data_bus_bridge
    import data_bus_bridge_pkg::*;
#(
    parameter     TAG     = "DataBusBridge",
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] db_addr,
    input  mem_access_t db_accessType,
    input  mem_len_t    db_memLen,
    input  logic [31:0] db_dataOut,
    output logic [31:0] db_dataIn,
    output logic        db_ready,
    output logic        db_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // TAG only prefixes simulation debug output; TIMEOUT must fit the 8-bit wait counter.
    if (TIMEOUT < 1 || TIMEOUT > 255 || $bits(TAG) == 0) begin : g_param_out_of_range
    end

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    mem_len_t    len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

`ifdef DATA_BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    bus_lane_align u_lane_align (
        .len_i     (len_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
`ifdef DATA_BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (db_accessType != ACC_NONE) begin
                    addr_d  = db_addr;
                    len_d   = db_memLen;
                    wdata_d = db_dataOut;
                    we_d    = (db_accessType == ACC_W);
                    if (is_misaligned(db_memLen, db_addr[1:0])) begin
                        state_d = ST_ERR;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_REQ;
`ifdef DATA_BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_REQ: begin
                // An acknowledge always wins over a timeout expiring in the same cycle.
                if (mem_ack) begin
                    rdata_d = lane_rdata;
                    state_d = ST_RESP;
                end
`ifdef DATA_BUS_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ST_ERR;
                        rdata_d = '0;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= LEN_B;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
`ifdef DATA_BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
`ifdef DATA_BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Request-qualified outputs are decoded from state so reset removes them without a clock.
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_be    = mem_req ? lane_be : 4'b0000;
    assign mem_addr  = addr_q[31:2];
    assign mem_wdata = lane_wdata;
    assign db_ready  = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign db_error  = (state_q == ST_ERR);
    assign db_dataIn = rdata_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed, table-driven bench for data_bus_bridge (TIMEOUT=4; adapts to DATA_BUS_TIMEOUT_EN).
module tb_data_bus_bridge;
    import data_bus_bridge_pkg::*;

    logic        clk;
    logic        res;
    logic [31:0] db_addr;
    mem_access_t db_accessType;
    mem_len_t    db_memLen;
    logic [31:0] db_dataOut;
    logic [31:0] db_dataIn;
    logic        db_ready;
    logic        db_error;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_checks = 0;
    int n_fail   = 0;

    data_bus_bridge #(.TAG("DataBusBridge"), .TIMEOUT(4)) dut (
        .clk           (clk),
        .res           (res),
        .db_addr       (db_addr),
        .db_accessType (db_accessType),
        .db_memLen     (db_memLen),
        .db_dataOut    (db_dataOut),
        .db_dataIn     (db_dataIn),
        .db_ready      (db_ready),
        .db_error      (db_error),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        mem_access_t acc;
        mem_len_t    len;
        logic [31:0] addr;
        logic [31:0] dout;
        logic [31:0] rdata;
        logic        err;
        logic [29:0] maddr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] din;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input mem_access_t acc, input mem_len_t len,
                             input logic [31:0] addr, input logic [31:0] dout);
        db_accessType = acc;
        db_memLen     = len;
        db_addr       = addr;
        db_dataOut    = dout;
    endtask

    initial begin
        // acc, len, addr, dout, rdata, err, maddr, be, we, wdata, din
        vecs[0] = '{ACC_W, LEN_W, 32'h8000_0004, 32'h1234_5678, 32'h0000_0000, 1'b0, 30'h2000_0001, 4'b1111, 1'b1, 32'h1234_5678, 32'h0000_0000};
        vecs[1] = '{ACC_R, LEN_B, 32'h8000_0003, 32'h0000_0000, 32'hAABB_CCDD, 1'b0, 30'h2000_0000, 4'b1000, 1'b0, 32'h0000_0000, 32'h0000_00AA};
        vecs[2] = '{ACC_R, LEN_W, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 30'h0,         4'b0000, 1'b0, 32'h0,         32'h0000_0000};
        vecs[3] = '{ACC_W, LEN_H, 32'h0000_0102, 32'h0000_BEEF, 32'h0000_0000, 1'b0, 30'h0000_0040, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'h0000_0000};
        vecs[4] = '{ACC_X, LEN_H, 32'h0000_1002, 32'h1234_5678, 32'h8001_7F02, 1'b0, 30'h0000_0400, 4'b1100, 1'b0, 32'h5678_5678, 32'h0000_8001};
        vecs[5] = '{ACC_W, LEN_B, 32'h0000_0001, 32'hFFFF_FF5A, 32'h1122_3344, 1'b0, 30'h0000_0000, 4'b0010, 1'b1, 32'h5A5A_5A5A, 32'h0000_0033};
        vecs[6] = '{ACC_W, LEN_H, 32'h0000_0003, 32'h0000_1111, 32'h0000_0000, 1'b1, 30'h0,         4'b0000, 1'b0, 32'h0,         32'h0000_0000};
        vecs[7] = '{ACC_R, LEN_B, 32'h0000_0000, 32'h0000_0000, 32'hAABB_CCDD, 1'b0, 30'h0000_0000, 4'b0001, 1'b0, 32'h0000_0000, 32'h0000_00DD};
        vecs[8] = '{ACC_R, LEN_W, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 30'h0000_0004, 4'b1111, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[9] = '{ACC_R, LEN_H, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 30'h0000_0000, 4'b0011, 1'b0, 32'h0000_0000, 32'h0000_F00D};

        res = 1'b0;
        start_req(ACC_NONE, LEN_B, 32'h0, 32'h0);
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        tick();
        tick();

        check("reset mem_req",   {31'h0, mem_req},   32'h0);
        check("reset mem_we",    {31'h0, mem_we},    32'h0);
        check("reset mem_be",    {28'h0, mem_be},    32'h0);
        check("reset mem_addr",  {2'b00, mem_addr},  32'h0);
        check("reset mem_wdata", mem_wdata,          32'h0);
        check("reset db_ready",  {31'h0, db_ready},  32'h0);
        check("reset db_error",  {31'h0, db_error},  32'h0);
        check("reset db_dataIn", db_dataIn,          32'h0);
        res = 1'b1;
        tick();

        // Acknowledge while no request is outstanding must be ignored.
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle ack mem_req",  {31'h0, mem_req},  32'h0);
            check("idle ack db_ready", {31'h0, db_ready}, 32'h0);
        end
        mem_ack = 1'b0;

        // Zero-wait transfers: accept at N, mem_req at N+1, db_ready at N+2.
        for (int v = 0; v < 10; v++) begin
            start_req(vecs[v].acc, vecs[v].len, vecs[v].addr, vecs[v].dout);
            mem_rdata = vecs[v].rdata;
            tick();
            db_accessType = ACC_NONE;
            if (vecs[v].err) begin
                check($sformatf("v%0d err mem_req", v),  {31'h0, mem_req},  32'h0);
                check($sformatf("v%0d err db_ready", v), {31'h0, db_ready}, 32'h1);
                check($sformatf("v%0d err db_error", v), {31'h0, db_error}, 32'h1);
                check($sformatf("v%0d err db_dataIn", v), db_dataIn,        32'h0);
            end else begin
                check($sformatf("v%0d mem_req", v),   {31'h0, mem_req},  32'h1);
                check($sformatf("v%0d mem_addr", v),  {2'b00, mem_addr}, {2'b00, vecs[v].maddr});
                check($sformatf("v%0d mem_be", v),    {28'h0, mem_be},   {28'h0, vecs[v].be});
                check($sformatf("v%0d mem_we", v),    {31'h0, mem_we},   {31'h0, vecs[v].we});
                check($sformatf("v%0d mem_wdata", v), mem_wdata,         vecs[v].wdata);
                check($sformatf("v%0d req db_ready", v), {31'h0, db_ready}, 32'h0);
                mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0;
                check($sformatf("v%0d db_ready", v),  {31'h0, db_ready}, 32'h1);
                check($sformatf("v%0d db_error", v),  {31'h0, db_error}, 32'h0);
                check($sformatf("v%0d resp mem_req", v), {31'h0, mem_req}, 32'h0);
                check($sformatf("v%0d db_dataIn", v), db_dataIn,         vecs[v].din);
            end
            tick();
            check($sformatf("v%0d idle db_ready", v), {31'h0, db_ready}, 32'h0);
            check($sformatf("v%0d idle db_error", v), {31'h0, db_error}, 32'h0);
            check($sformatf("v%0d hold db_dataIn", v), db_dataIn,        vecs[v].din);
        end

        // Three wait states, ack on the fourth REQ cycle (also the timeout-expiry cycle when enabled).
        start_req(ACC_R, LEN_H, 32'h0000_0006, 32'h0);
        mem_rdata = 32'h5555_5555;
        tick();
        db_accessType = ACC_NONE;
        for (int i = 0; i < 3; i++) begin
            check("wait mem_req",  {31'h0, mem_req},  32'h1);
            check("wait mem_be",   {28'h0, mem_be},   32'h0000_000C);
            check("wait mem_addr", {2'b00, mem_addr}, 32'h0000_0001);
            check("wait db_ready", {31'h0, db_ready}, 32'h0);
            tick();
        end
        check("wait4 mem_req", {31'h0, mem_req}, 32'h1);
        mem_rdata = 32'h1234_ABCD;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        check("wait resp db_ready", {31'h0, db_ready}, 32'h1);
        check("wait resp db_error", {31'h0, db_error}, 32'h0);
        check("wait resp db_dataIn", db_dataIn,        32'h0000_1234);
        tick();

        // Memory never acknowledges.
        start_req(ACC_R, LEN_W, 32'h0000_0040, 32'h0);
        tick();
        db_accessType = ACC_NONE;
        for (int i = 0; i < 4; i++) begin
            check("noack mem_req",  {31'h0, mem_req},  32'h1);
            check("noack db_ready", {31'h0, db_ready}, 32'h0);
            tick();
        end
`ifdef DATA_BUS_TIMEOUT_EN
        check("timeout mem_req",   {31'h0, mem_req},  32'h0);
        check("timeout db_ready",  {31'h0, db_ready}, 32'h1);
        check("timeout db_error",  {31'h0, db_error}, 32'h1);
        check("timeout db_dataIn", db_dataIn,         32'h0);
        tick();
        check("timeout idle db_ready", {31'h0, db_ready}, 32'h0);
        start_req(ACC_W, LEN_W, 32'h0000_0080, 32'hA5A5_A5A5);
        tick();
        db_accessType = ACC_NONE;
        check("pre-reset mem_req", {31'h0, mem_req}, 32'h1);
`else
        for (int i = 0; i < 16; i++) begin
            check("hang mem_req",  {31'h0, mem_req},  32'h1);
            check("hang db_ready", {31'h0, db_ready}, 32'h0);
            tick();
        end
`endif

        // Reset in the middle of REQ: mem_req drops without waiting for a clock edge.
        #2;
        res = 1'b0;
        #1;
        check("async reset mem_req",  {31'h0, mem_req},  32'h0);
        check("async reset db_ready", {31'h0, db_ready}, 32'h0);
        check("async reset mem_be",   {28'h0, mem_be},   32'h0);
        tick();
        res = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post reset mem_req",  {31'h0, mem_req},  32'h0);
            check("post reset db_ready", {31'h0, db_ready}, 32'h0);
        end

        // The bridge must still serve a request after reset.
        start_req(ACC_R, LEN_B, 32'h0000_0002, 32'h0);
        mem_rdata = 32'h00EE_0000;
        tick();
        db_accessType = ACC_NONE;
        check("after reset mem_req", {31'h0, mem_req}, 32'h1);
        check("after reset mem_be",  {28'h0, mem_be},  32'h0000_0004);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("after reset db_ready",  {31'h0, db_ready}, 32'h1);
        check("after reset db_dataIn", db_dataIn,         32'h0000_00EE);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_bus_bridge.md
DATA_BUS_BRIDGE -- requirements
Module: data_bus_bridge

Interface
REQ-001 SHALL have parameter TAG, default "DataBusBridge", used as the debug-print prefix.
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the memory-acknowledge wait limit in cycles (range 1..255).
REQ-003 SHALL have ports: clk  in  1  the single clock.
REQ-004 SHALL have ports: res  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: db_addr  in  32  CPU byte address.
REQ-006 SHALL have ports: db_accessType  in  MEM_ACCESS  NONE/R/W/X request kind.
REQ-007 SHALL have ports: db_memLen  in  MEM_LEN  B/H/W access size.
REQ-008 SHALL have ports: db_dataOut  in  32  CPU write data, right-justified.
REQ-009 SHALL have ports: db_dataIn  out  32  read data to CPU, right-justified.
REQ-010 SHALL have ports: db_ready  out  1  transfer complete, one-cycle pulse.
REQ-011 SHALL have ports: db_error  out  1  misalign/timeout, pulses with db_ready.
REQ-012 SHALL have ports: mem_req  out  1  memory request.
REQ-013 SHALL have ports: mem_we  out  1  write enable.
REQ-014 SHALL have ports: mem_addr  out  30  word address (byte address [31:2]).
REQ-015 SHALL have ports: mem_be  out  4  byte enables, bit n = byte lane n.
REQ-016 SHALL have ports: mem_wdata  out  32  lane-steered write data.
REQ-017 SHALL have ports: mem_rdata  in  32  memory read word.
REQ-018 SHALL have ports: mem_ack  in  1  memory done, sampled only while mem_req=1.

Function
REQ-019 SHALL implement the FSM states IDLE, REQ, RESP and ERR, all state transitions registered.
REQ-020 IDLE: when db_accessType≠NONE, SHALL latch addr, len, write data and kind (W → write; R/X → read).
REQ-021 IDLE acceptance SHALL go to ERR if misaligned (H with addr[0]=1, or W with addr[1:0]≠0), otherwise to REQ.
REQ-022 REQ SHALL hold mem_req=1 with stable mem_addr/mem_we/mem_be/mem_wdata; on mem_ack=1 it SHALL capture mem_rdata and go to RESP.
REQ-023 RESP and ERR SHALL each last exactly one cycle with db_ready=1, then go to IDLE; db_error=1 only in ERR.
REQ-024 db_ready SHALL be 0 in IDLE and REQ, so back-to-back requests have at least one IDLE cycle between them.
REQ-025 Byte enables SHALL be little-endian: B → 4'b0001<<addr[1:0]; H → 4'b0011<<{addr[1],1'b0}; W → 4'b1111.
REQ-026 Write data SHALL be replicated: B → {4{d[7:0]}}; H → {2{d[15:0]}}; W → d.
REQ-027 Read data SHALL be shifted right by 8×addr[1:0] and zero-extended above the access length; sign extension stays in the CPU.
REQ-028 db_dataIn SHALL hold its last value outside RESP; in ERR it SHALL be 0.
REQ-029 Latency with zero-wait memory (ack in the first REQ cycle) SHALL be: accept at cycle N, mem_req at N+1, db_ready at N+2.
REQ-030 If db_accessType drops to NONE during REQ, the memory transaction SHALL still complete and the RESP pulse SHALL still occur.
REQ-031 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-032 When res=0, the block SHALL asynchronously enter IDLE, with mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, db_ready=0, db_error=0, db_dataIn=0 and the timeout counter at 0.
REQ-033 Reset mid-transaction SHALL drop mem_req immediately, with no db_ready pulse.

Configuration
REQ-034 With DATA_BUS_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering REQ and count each REQ cycle without ack.
REQ-035 With DATA_BUS_TIMEOUT_EN defined, when the counter reaches TIMEOUT the block SHALL drop mem_req and go to ERR; an ack in that same cycle SHALL take priority (RESP).
REQ-036 Without DATA_BUS_TIMEOUT_EN, REQ SHALL wait indefinitely and the counter SHALL not exist.

Structure
REQ-037 The MEM_ACCESS and MEM_LEN encodings SHALL come from the shared DataBus.vh; the bridge state encodings SHALL be local constants.
REQ-038 Lane steering (byte enables, write replicate, read shift/extend) SHALL be a combinational sub-module bus_lane_align.

Verification
REQ-039 Write W 0x12345678 to 0x80000004, ack in the first cycle → mem_addr=0x20000001, mem_be=1111, mem_we=1, db_ready at N+2.
REQ-040 Read B at 0x80000003 with mem_rdata=0xAABBCCDD → mem_be=1000, db_dataIn=0x000000AA, db_error=0.
REQ-041 Write H 0x0000BEEF to 0x00000102 → mem_be=1100, mem_wdata=0xBEEFBEEF.
REQ-042 Read W at 0x00000002 → no mem_req, db_ready=db_error=1 one cycle after acceptance, db_dataIn=0.
REQ-043 With DATA_BUS_TIMEOUT_EN and TIMEOUT=4, never ack → mem_req high for 4 cycles, then ERR pulse; without the macro → mem_req stays high.
REQ-044 Assert res=0 during REQ → mem_req=0 in the same cycle, IDLE after release, no db_ready.
